// File: rtl/jk_cmd_arbiter.sv
// Two-requester round-robin command arbiter driving an N-bit JK flip-flop bank.
// Each granted command runs IDLE -> EXEC -> ACK and completes with a four-phase handshake.
module jk_cmd_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0,
   input  logic         req1,
   input  logic [1:0]   cmd0,
   input  logic [1:0]   cmd1,
   input  logic [N-1:0] mask0,
   input  logic [N-1:0] mask1,
   output logic         ack0,
   output logic         ack1,
   output logic [N-1:0] j,
   output logic [N-1:0] k,
   output logic [N-1:0] q,
   output logic         busy,
   output logic         gnt_id,
   output logic [7:0]   op_count
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] ACK  = 2'd2;

   logic [1:0]   state_q, state_d;
   logic         last_q, last_d;
   logic         gnt_q, gnt_d;
   logic [1:0]   cmd_q, cmd_d;
   logic [N-1:0] mask_q, mask_d;
   logic [N-1:0] bank_q, bank_d;
   logic [7:0]   cnt_q, cnt_d;

   logic         pick;
   logic         gnt_req;
   logic [N-1:0] j_v, k_v;

   // cmd[1] asserts J and cmd[0] asserts K on the masked bits, only while executing.
   always_comb begin
      j_v = '0;
      k_v = '0;
      if (state_q == EXEC) begin
         j_v = mask_q & {N{cmd_q[1]}};
         k_v = mask_q & {N{cmd_q[0]}};
      end
   end

   // On a tie the requester not granted last wins; otherwise the lone requester wins.
   assign pick    = (req0 && req1) ? ~last_q : req1;
   assign gnt_req = gnt_q ? req1 : req0;

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
      state_d = state_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      cmd_d   = cmd_q;
      mask_d  = mask_q;
      bank_d  = bank_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               gnt_d   = pick;
               last_d  = pick;
               cmd_d   = pick ? cmd1 : cmd0;
               mask_d  = pick ? mask1 : mask0;
               state_d = EXEC;
            end
         end
         EXEC: begin
            bank_d  = (j_v & ~bank_q) | (~k_v & bank_q);
            cnt_d   = cnt_q + 8'd1;
            state_d = ACK;
         end
         ACK: begin
            if (!gnt_req) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         gnt_q   <= 1'b0;
         cmd_q   <= 2'b00;
         mask_q  <= '0;
         bank_q  <= '0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         cmd_q   <= cmd_d;
         mask_q  <= mask_d;
         bank_q  <= bank_d;
         cnt_q   <= cnt_d;
      end
   end

   assign j        = j_v;
   assign k        = k_v;
   assign q        = bank_q;
   assign busy     = (state_q != IDLE);
   assign gnt_id   = gnt_q;
   assign op_count = cnt_q;
   assign ack0     = (state_q == ACK) && !gnt_q;
   assign ack1     = (state_q == ACK) &&  gnt_q;

endmodule

// File: tb/tb_jk_cmd_arbiter.sv
// Bench for jk_cmd_arbiter: directed vector table, handshake corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_jk_cmd_arbiter;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0, req1;
   logic [1:0]   cmd0, cmd1;
   logic [N-1:0] mask0, mask1;
   logic         ack0, ack1;
   logic [N-1:0] j, k, q;
   logic         busy, gnt_id;
   logic [7:0]   op_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   jk_cmd_arbiter #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1),
      .cmd0(cmd0), .cmd1(cmd1),
      .mask0(mask0), .mask1(mask1),
      .ack0(ack0), .ack1(ack1),
      .j(j), .k(k), .q(q),
      .busy(busy), .gnt_id(gnt_id), .op_count(op_count)
   );

   // Observed bundle: j, k, q, ack0, ack1, busy, gnt_id, op_count
   logic [23:0] obs;
   assign obs = {j, k, q, ack0, ack1, busy, gnt_id, op_count};

   typedef struct {
      logic       r0, r1;
      logic [1:0] c0, c1;
      logic [3:0] m0, m1;
      logic [3:0] ej, ek, eq;
      logic       ea0, ea1, ebusy, egnt;
      logic [7:0] ecnt;
   } vec_t;

   function automatic logic [23:0] pk(input logic [3:0] ej, input logic [3:0] ek,
                                      input logic [3:0] eq, input logic ea0, input logic ea1,
                                      input logic eb, input logic eg, input logic [7:0] ec);
      return {ej, ek, eq, ea0, ea1, eb, eg, ec};
   endfunction

   task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0 = 1'b0; req1 = 1'b0;
      cmd0 = 2'b00; cmd1 = 2'b00;
      mask0 = '0;  mask1 = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   // Full four-phase command; reports a timeout through the flag.
   task automatic run_cmd(input logic who, input logic [1:0] c, input logic [3:0] m,
                          output bit timed_out);
      bit seen;
      timed_out = 1'b0;
      seen = 1'b0;
      if (who) begin req1 = 1'b1; cmd1 = c; mask1 = m; end
      else     begin req0 = 1'b1; cmd0 = c; mask0 = m; end
      for (int i = 0; i < 8 && !seen; i++) begin
         tick();
         seen = who ? ack1 : ack0;
      end
      if (!seen) timed_out = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         tick();
         seen = !busy;
      end
      if (!seen) timed_out = 1'b1;
   endtask

   function automatic logic [3:0] apply_cmd(input logic [1:0] c, input logic [3:0] m,
                                            input logic [3:0] cur);
      case (c)
         2'b01:   return cur & ~m;
         2'b10:   return cur | m;
         2'b11:   return cur ^ m;
         default: return cur;
      endcase
   endfunction

   vec_t tbl[13];

   initial begin
      bit        tmo;
      int        n_tmo;
      int        grants[$];
      bit        prev_busy;
      int        phase;
      logic      m_last, m_gnt;
      logic [1:0] m_cmd;
      logic [3:0] m_mask, m_q, ej, ek;
      logic [7:0] m_cnt;
      logic      win;

      //           r0    r1    c0     c1     m0       m1       j        k        q        a0    a1    busy  gnt   cnt
      tbl[0]  = '{1'b1, 1'b0, 2'b10, 2'b00, 4'b0101, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
      tbl[1]  = '{1'b1, 1'b0, 2'b01, 2'b00, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0101, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
      tbl[2]  = '{1'b1, 1'b0, 2'b01, 2'b00, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0101, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
      tbl[3]  = '{1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
      tbl[4]  = '{1'b0, 1'b1, 2'b00, 2'b00, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0101, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1};
      tbl[5]  = '{1'b0, 1'b1, 2'b00, 2'b00, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0101, 1'b0, 1'b1, 1'b1, 1'b1, 8'd2};
      tbl[6]  = '{1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
      tbl[7]  = '{1'b1, 1'b1, 2'b00, 2'b11, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0101, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
      tbl[8]  = '{1'b1, 1'b1, 2'b00, 2'b11, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0101, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3};
      tbl[9]  = '{1'b0, 1'b1, 2'b00, 2'b11, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3};
      tbl[10] = '{1'b0, 1'b1, 2'b00, 2'b11, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0101, 1'b0, 1'b0, 1'b1, 1'b1, 8'd3};
      tbl[11] = '{1'b0, 1'b1, 2'b00, 2'b11, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b1010, 1'b0, 1'b1, 1'b1, 1'b1, 8'd4};
      tbl[12] = '{1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4};

      idle_inputs();
      rst_n = 1'b0;
      #1;
      check("reset_state", obs, 24'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Directed table: set/hold, cmd change after grant, tie-break, pending request, toggle
      for (int i = 0; i < 13; i++) begin
         req0 = tbl[i].r0; req1 = tbl[i].r1;
         cmd0 = tbl[i].c0; cmd1 = tbl[i].c1;
         mask0 = tbl[i].m0; mask1 = tbl[i].m1;
         tick();
         check($sformatf("vec%0d", i), obs,
               pk(tbl[i].ej, tbl[i].ek, tbl[i].eq, tbl[i].ea0, tbl[i].ea1,
                  tbl[i].ebusy, tbl[i].egnt, tbl[i].ecnt));
      end

      // Asynchronous reset mid-cycle takes effect without a clock edge
      #2 rst_n = 1'b0;
      #1 check("async_reset", obs, 24'h0);
      tick();
      rst_n = 1'b1;

      // First tie after reset goes to requester 0; reset during EXEC aborts
      req0 = 1'b1; cmd0 = 2'b10; mask0 = 4'b1111;
      req1 = 1'b1; cmd1 = 2'b11; mask1 = 4'b1111;
      tick();
      check("tie_after_reset", obs, pk(4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
      #2 rst_n = 1'b0;
      #1 check("abort_immediate", obs, 24'h0);
      tick();
      check("abort_no_ack", obs, 24'h0);
      rst_n = 1'b1;
      tick();
      check("rearbitrate", obs, pk(4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
      tick();
      check("rearb_done", obs, pk(4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1));

      // Fairness: both requesters keep asking, each drops for one cycle after its ack
      idle_inputs();
      do_reset();
      req0 = 1'b1; req1 = 1'b1; cmd0 = 2'b00; cmd1 = 2'b00;
      prev_busy = 1'b0;
      for (int c = 0; c < 60 && grants.size() < 4; c++) begin
         tick();
         if (busy && !prev_busy) grants.push_back(int'(gnt_id));
         prev_busy = busy;
         req0 = !ack0;
         req1 = !ack1;
      end
      check("fair_count", 24'(grants.size()), 24'd4);
      for (int g = 0; g < grants.size() && g < 4; g++)
         check($sformatf("fair_grant%0d", g), 24'(grants[g]), 24'(g % 2));

      // Counter wrap over 256 hold commands
      idle_inputs();
      do_reset();
      n_tmo = 0;
      for (int c = 0; c < 256; c++) begin
         run_cmd(1'b0, 2'b00, 4'b1111, tmo);
         if (tmo) n_tmo++;
         if (c == 254) check("count_255", 24'(op_count), 24'd255);
      end
      check("wrap_timeouts", 24'(n_tmo), 24'd0);
      check("wrap_result", obs, pk(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));

      // Randomized traffic against a command-level model
      idle_inputs();
      do_reset();
      phase = 0; m_last = 1'b1; m_gnt = 1'b0;
      m_cmd = 2'b00; m_mask = '0; m_q = '0; m_cnt = 8'd0;
      for (int c = 0; c < 2000; c++) begin
         req0 = ($urandom_range(0, 9) < 6);
         req1 = ($urandom_range(0, 9) < 6);
         cmd0 = 2'($urandom); cmd1 = 2'($urandom);
         mask0 = 4'($urandom); mask1 = 4'($urandom);
         tick();
         case (phase)
            0: if (req0 || req1) begin
                  if (req0 && req1) win = !m_last;
                  else              win = req1;
                  m_gnt = win; m_last = win;
                  m_cmd = win ? cmd1 : cmd0;
                  m_mask = win ? mask1 : mask0;
                  phase = 1;
               end
            1: begin
                  m_q = apply_cmd(m_cmd, m_mask, m_q);
                  m_cnt = m_cnt + 8'd1;
                  phase = 2;
               end
            default: if (!(m_gnt ? req1 : req0)) phase = 0;
         endcase
         ej = '0; ek = '0;
         if (phase == 1) begin
            if (m_cmd == 2'b10 || m_cmd == 2'b11) ej = m_mask;
            if (m_cmd == 2'b01 || m_cmd == 2'b11) ek = m_mask;
         end
         check("random", obs, pk(ej, ek, m_q, phase == 2 && !m_gnt, phase == 2 && m_gnt,
                                 phase != 0, m_gnt, m_cnt));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/jk_cmd_arbiter.md
JK_CMD_ARBITER -- requirements
Module: jk_cmd_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the width of the JK flip-flop bank.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have ports req0 and req1, input, 1 bit each: command request from requester 0 and requester 1.
REQ-005 The block SHALL have ports cmd0 and cmd1, input, 2 bits each: command code (00 hold, 01 reset, 10 set, 11 toggle).
REQ-006 The block SHALL have ports mask0 and mask1, input, N bits each: bits of the bank the command applies to.
REQ-007 The block SHALL have ports ack0 and ack1, output, 1 bit each: command-complete acknowledge.
REQ-008 The block SHALL have port j, output, N bits: J inputs driven onto the bank.
REQ-009 The block SHALL have port k, output, N bits: K inputs driven onto the bank.
REQ-010 The block SHALL have port q, output, N bits: JK bank state.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 The block SHALL have port gnt_id, output, 1 bit: index of the current or last granted requester.
REQ-013 The block SHALL have port op_count, output, 8 bits: count of completed commands.

Function
REQ-014 The block SHALL have FSM states IDLE, EXEC and ACK.
REQ-015 In IDLE with at least one req high at a rising edge, the block SHALL grant one requester, latch its cmd and mask, set gnt_id, and go to EXEC.
REQ-016 Arbitration SHALL be round-robin: when both req are high, the requester not granted last wins; when only one req is high, that requester wins.
REQ-017 The last-grant pointer SHALL update only on a grant.
REQ-018 In EXEC, for each bit i with mask[i]=1, j[i]/k[i] SHALL be 0/0 for hold, 0/1 for reset, 1/0 for set and 1/1 for toggle.
REQ-019 In EXEC, every bit with mask[i]=0, and every bit in any other state, SHALL have j[i]=k[i]=0.
REQ-020 On the edge leaving EXEC, each bit SHALL update by the JK rule (00 keep, 01 clear, 10 set, 11 invert), the FSM SHALL go to ACK, and op_count SHALL increment.
REQ-021 op_count SHALL wrap from 255 to 0.
REQ-022 In ACK, the granted ack SHALL be high and the other ack SHALL be low.
REQ-023 ACK SHALL be held until the granted req is sampled low, then the FSM SHALL return to IDLE with ack low in that IDLE cycle (four-phase handshake).
REQ-024 Latency SHALL be: req sampled at edge E0, EXEC in the following cycle, q updated and ack high after E1; minimum grant-to-grant spacing is 3 cycles.
REQ-025 Changes to cmd or mask after the grant edge SHALL have no effect on the executing command.
REQ-026 A req from the non-granted requester that arrives during EXEC or ACK SHALL stay pending and be arbitrated in the next IDLE.
REQ-027 q SHALL change only on the edge leaving EXEC.

Reset
REQ-028 While rst_n=0, regardless of clk, the block SHALL force state IDLE, q=0, j=0, k=0, ack0=ack1=0, busy=0, gnt_id=0, op_count=0, and last-grant pointer=1 so that requester 0 wins the first tie.
REQ-029 A reset during EXEC or ACK SHALL abort the command: q=0, op_count not incremented, and no ack.
REQ-030 Requests still high after rst_n rises SHALL be re-arbitrated from IDLE.

Verification
REQ-031 Reset check: with N=4, assert rst_n=0 mid-cycle -> q=0000, ack0=ack1=0, busy=0 and op_count=0 immediately, without waiting for a clock edge.
REQ-032 Set/hold check: from q=0000, req0 with cmd0=10 and mask0=0101 -> j=0101 and k=0000 in EXEC; then q=0101 and ack0=1; ack0 stays high until req0 drops; op_count=1.
REQ-033 Tie-break check: after reset, req0 and req1 raised in the same cycle, with cmd1=11, mask1=1111 and q=0101 -> requester 0 is served first (gnt_id=0), then requester 1 (gnt_id=1), and the toggle gives q=1010.
REQ-034 Fairness check: both req held high, each dropped and re-raised one cycle after its ack -> grants alternate 0,1,0,1 over four commands.
REQ-035 Reset-abort check: assert rst_n=0 during EXEC of a set with mask 1111 -> q=0000, no ack pulse, op_count unchanged (0).
REQ-036 Wrap check: complete 256 hold commands (cmd=00, mask=1111) -> q unchanged and op_count ends at 0 (255 -> 0 on the 256th command).
